decodificador: RTL and testbench

DECODIFICADOR -- requirements
Module: decodificador

---
 rtl/decodificador.sv | 143 ++++++++++++++
 tb/tb_decodificador.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decodificador.sv
// rtl/decodificador.sv - edge-triggered Gray-to-binary decoder feeding a 2-entry output FIFO
// Optional odd-parity input check enabled by defining DECODIFICADOR_PARITY_EN.
module decodificador (
  input  logic       clk,
  input  logic       reset,
  input  logic       ready,
  input  logic       S0,
  input  logic       S1,
  input  logic       S2,
  input  logic       S3,
  input  logic       ack,
`ifdef DECODIFICADOR_PARITY_EN
  input  logic       P,
  output logic       perr,
`endif
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  output logic       valid,
  output logic       full,
  output logic [3:0] count,
  output logic       overflow
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_ready_q;
  logic [3:0] r_head;
  logic [3:0] r_tail;
  logic [3:0] w_head_nxt;
  logic [3:0] w_tail_nxt;
  logic [3:0] r_count;
  logic       r_overflow;
  logic       w_push_req;
  logic       w_push;
  logic       w_pop;
  logic       w_accept;
  logic       w_drop;
  logic [3:0] w_word;

  // ready_q resets high so a level held across reset release is not seen as a new pulse
  assign w_push_req = ready & ~r_ready_q;
  assign w_word     = {S0, S0 ^ S1, S0 ^ S1 ^ S2, S0 ^ S1 ^ S2 ^ S3};
  assign w_pop      = ack & (r_state != EMPTY);

`ifdef DECODIFICADOR_PARITY_EN
  logic w_par_ok;
  logic r_perr;

  assign w_par_ok = ^{S0, S1, S2, S3, P};
  assign w_push   = w_push_req & w_par_ok;
  assign perr     = r_perr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perr <= 1'b0;
    end else begin
      r_perr <= w_push_req & ~w_par_ok;
    end
  end
`else
  assign w_push = w_push_req;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_head_nxt  = r_head;
    w_tail_nxt  = r_tail;
    w_accept    = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_push) begin
          w_head_nxt  = w_word;
          w_state_nxt = ONE;
          w_accept    = 1'b1;
        end
      end
      ONE: begin
        if (w_push && w_pop) begin
          w_head_nxt = w_word;
          w_accept   = 1'b1;
        end else if (w_push) begin
          w_tail_nxt  = w_word;
          w_state_nxt = FULL;
          w_accept    = 1'b1;
        end else if (w_pop) begin
          w_state_nxt = EMPTY;
        end
      end
      FULL: begin
        // pop is taken first, which frees the slot the incoming word needs
        if (w_push && w_pop) begin
          w_head_nxt = r_tail;
          w_tail_nxt = w_word;
          w_accept   = 1'b1;
        end else if (w_pop) begin
          w_head_nxt  = r_tail;
          w_state_nxt = ONE;
        end else if (w_push) begin
          w_drop = 1'b1;
        end
      end
      default: begin
        w_state_nxt = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= EMPTY;
      r_ready_q  <= 1'b1;
      r_head     <= 4'b0000;
      r_tail     <= 4'b0000;
      r_count    <= 4'd0;
      r_overflow <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ready_q <= ready;
      r_head    <= w_head_nxt;
      r_tail    <= w_tail_nxt;
      r_count   <= r_count + {3'b000, w_accept};
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign valid        = (r_state != EMPTY);
  assign full         = (r_state == FULL);
  assign {A, B, C, D} = valid ? r_head : 4'b0000;
  assign count        = r_count;
  assign overflow     = r_overflow;

endmodule

// File: tb/tb_decodificador.sv
// tb/tb_decodificador.sv - randomized and directed self-checking bench for decodificador
// Honors DECODIFICADOR_PARITY_EN to exercise the optional parity port.
module tb_decodificador;

  logic       clk;
  logic       reset;
  logic       ready;
  logic [3:0] s;
  logic       ack;
  logic       A, B, C, D;
  logic       valid;
  logic       full;
  logic [3:0] count;
  logic       overflow;
`ifdef DECODIFICADOR_PARITY_EN
  logic       P;
  logic       perr;
`endif

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  decodificador dut (
    .clk      (clk),
    .reset    (reset),
    .ready    (ready),
    .S0       (s[3]),
    .S1       (s[2]),
    .S2       (s[1]),
    .S3       (s[0]),
    .ack      (ack),
`ifdef DECODIFICADOR_PARITY_EN
    .P        (P),
    .perr     (perr),
`endif
    .A        (A),
    .B        (B),
    .C        (C),
    .D        (D),
    .valid    (valid),
    .full     (full),
    .count    (count),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: each Gray bit folds in every more-significant bit
  function automatic logic [3:0] g2b(input logic [3:0] g);
    return g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
  endfunction

  logic [3:0] mq[$];
  bit         m_rq   = 1;
  int         m_cnt  = 0;
  bit         m_ovf  = 0;
  bit         m_perr = 0;

  always @(posedge clk) begin
    bit req;
    bit ok;
    if (reset) begin
      mq.delete();
      m_rq   = 1;
      m_cnt  = 0;
      m_ovf  = 0;
      m_perr = 0;
    end else begin
      req = ready && !m_rq;
      ok  = 1;
`ifdef DECODIFICADOR_PARITY_EN
      ok     = ($countones({s, P}) % 2) == 1;
      m_perr = req && !ok;
`endif
      if (ack && mq.size() > 0) void'(mq.pop_front());
      if (req && ok) begin
        if (mq.size() < 2) begin
          mq.push_back(g2b(s));
          m_cnt = (m_cnt + 1) % 16;
        end else begin
          m_ovf = 1;
        end
      end
      m_rq = ready;
    end
  end

  always @(negedge clk) begin
    logic [11:0] act;
    logic [11:0] exp;
    logic [3:0]  head;
    if (chk_en) begin
      head = (mq.size() > 0) ? mq[0] : 4'b0000;
      exp  = {head, mq.size() > 0, mq.size() == 2, 4'(m_cnt), m_ovf, 1'b0};
      act  = {A, B, C, D, valid, full, count, overflow, 1'b0};
`ifdef DECODIFICADOR_PARITY_EN
      exp[0] = m_perr;
      act[0] = perr;
`endif
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL model_outputs t=%0t actual=%b required=%b", $time, act, exp);
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic set_word(input logic [3:0] w);
    s = w;
`ifdef DECODIFICADOR_PARITY_EN
    P = ~(^w);
`endif
  endtask

  task automatic push(input logic [3:0] w);
    set_word(w);
    ready = 1'b1;
    cyc();
    ready = 1'b0;
    cyc();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ready = 1'b0;
    ack   = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
  endtask

  initial begin
    reset = 1'b1;
    ready = 1'b0;
    ack   = 1'b0;
    s     = 4'b0000;
`ifdef DECODIFICADOR_PARITY_EN
    P     = 1'b0;
`endif
    cyc();
    chk_en = 1;
    chk("reset_state", {A, B, C, D, valid, full, overflow, 1'b0}, 8'b0);
    chk("reset_count", {4'b0, count}, 8'd0);
    do_reset();

    // one push per ready pulse however long the pulse is
    set_word(4'b0110);
    ready = 1'b1;
    cyc();
    chk("first_word", {A, B, C, D, valid, 3'b0}, {4'b0100, 1'b1, 3'b0});
    cyc();
    cyc();
    ready = 1'b0;
    cyc();
    chk("long_pulse_count", {4'b0, count}, 8'd1);
    ack = 1'b1;
    cyc();
    ack = 1'b0;

    push(4'b1000);
    push(4'b0001);
    chk("fill_full", {A, B, C, D, full, 3'b0}, {4'b1111, 1'b1, 3'b0});
    ack = 1'b1;
    cyc();
    ack = 1'b0;
    chk("pop_one", {A, B, C, D, full, 3'b0}, {4'b0001, 1'b0, 3'b0});
    ack = 1'b1;
    cyc();
    ack = 1'b0;
    chk("pop_empty", {A, B, C, D, valid, 3'b0}, 8'b0);

    push(4'b1000);
    push(4'b0001);
    push(4'b1101);
    chk("drop_flags", {A, B, C, D, overflow, full, 2'b0}, {4'b1111, 2'b11, 2'b0});
    chk("drop_count", {4'b0, count}, 8'd5);
    set_word(4'b1101);
    ready = 1'b1;
    ack   = 1'b1;
    cyc();
    ready = 1'b0;
    ack   = 1'b0;
    cyc();
    chk("pushpop_full", {A, B, C, D, full, 3'b0}, {4'b0001, 1'b1, 3'b0});
    chk("pushpop_count", {4'b0, count}, 8'd6);
    ack = 1'b1;
    cyc();
    ack = 1'b0;
    chk("order_kept", {A, B, C, D, 4'b0}, {4'b1001, 4'b0});
    ack = 1'b1;
    cyc();
    ack = 1'b0;

    do_reset();
    ack = 1'b1;
    for (int i = 0; i < 17; i++) push(4'($urandom));
    ack = 1'b0;
    chk("count_wrap", {4'b0, count}, 8'd1);
    chk("wrap_no_ovf", {overflow, valid, 6'b0}, 8'b0);

    reset = 1'b1;
    set_word(4'b0110);
    ready = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
    cyc();
    chk("ready_across_reset", {valid, 3'b0, count}, 8'd0);
    ready = 1'b0;
    cyc();

`ifdef DECODIFICADOR_PARITY_EN
    s     = 4'b0110;
    P     = 1'b0;
    ready = 1'b1;
    cyc();
    ready = 1'b0;
    chk("perr_set", {perr, valid, 2'b0, count}, {1'b1, 7'd0});
    cyc();
    chk("perr_clear", {perr, 7'b0}, 8'b0);
    P     = 1'b1;
    ready = 1'b1;
    cyc();
    ready = 1'b0;
    chk("parity_ok", {A, B, C, D, valid, perr, 2'b0}, {4'b0100, 1'b1, 3'b0});
    cyc();
`endif

    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      ready = ($urandom_range(0, 2) != 0) ? ~ready : ready;
      ack   = ($urandom_range(0, 2) == 0);
      s     = 4'($urandom);
`ifdef DECODIFICADOR_PARITY_EN
      P     = ($urandom_range(0, 4) == 0) ? (^s) : ~(^s);
`endif
      cyc();
    end
    reset = 1'b0;
    ready = 1'b0;
    ack   = 1'b0;
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
